// File: rtl/hamming_match_ctrl_if.sv
// Bus between the descriptor matcher controller, the descriptor buffer,
// the Hamming distance unit and the result consumer.
interface hamming_match_ctrl_if #(
    parameter int unsigned IDX_W = 6
);
    logic               i_start;
    logic [255:0]       i_src_desc;
    logic [IDX_W:0]     i_dst_num;
    logic               o_dst_ren;
    logic [IDX_W-1:0]   o_dst_addr;
    logic [255:0]       i_dst_desc;
    logic               o_ham_valid;
    logic [255:0]       o_ham_src;
    logic [255:0]       o_ham_dst;
    logic               i_ham_valid;
    logic [8:0]         i_ham_dist;
    logic               o_busy;
    logic               o_done;
    logic [IDX_W-1:0]   o_best_idx;
    logic [8:0]         o_best_dist;
    logic [8:0]         o_second_dist;
    logic               o_match_valid;

    modport slave (
        input  i_start, i_src_desc, i_dst_num, i_dst_desc, i_ham_valid, i_ham_dist,
        output o_dst_ren, o_dst_addr, o_ham_valid, o_ham_src, o_ham_dst,
               o_busy, o_done, o_best_idx, o_best_dist, o_second_dist, o_match_valid
    );

    modport master (
        output i_start, i_src_desc, i_dst_num, i_dst_desc, i_ham_valid, i_ham_dist,
        input  o_dst_ren, o_dst_addr, o_ham_valid, o_ham_src, o_ham_dst,
               o_busy, o_done, o_best_idx, o_best_dist, o_second_dist, o_match_valid
    );
endinterface

// File: rtl/hamming_match_ctrl.sv
// Brute-force descriptor matcher: streams destination descriptors through the
// external 2-stage Hamming unit and tracks best / second-best distance.
module hamming_match_ctrl #(
    parameter int unsigned N_DST    = 64,
    parameter int unsigned IDX_W    = 6,
    parameter int unsigned MAX_DIST = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    hamming_match_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    localparam logic [IDX_W:0] NUM_MAX = (IDX_W+1)'(N_DST);
    localparam logic [8:0]     MAX_D   = 9'(MAX_DIST);

    state_t             r_state;
    state_t             w_state_nxt;

    logic [255:0]       r_src;
    logic [IDX_W:0]     r_num;
    logic [IDX_W:0]     r_issue_cnt;
    logic [IDX_W:0]     r_res_cnt;
    logic               r_dst_ren;
    logic               r_ham_valid;
    logic               r_busy;
    logic               r_done;
    logic               r_match_valid;
    logic [IDX_W-1:0]   r_best_idx;
    logic [8:0]         r_best;
    logic [8:0]         r_second;

    logic               w_start_acc;
    logic               w_res_acc;
    logic [IDX_W:0]     w_num_lat;
    logic [IDX_W:0]     w_issue_inc;
    logic [IDX_W:0]     w_res_inc;
    logic               w_last_issue;
    logic               w_last_res;

    logic [IDX_W:0]     w_issue_nxt;
    logic [IDX_W:0]     w_res_nxt;
    logic               w_dst_ren_nxt;
    logic [IDX_W-1:0]   w_best_idx_nxt;
    logic [8:0]         w_best_nxt;
    logic [8:0]         w_second_nxt;
    logic [10:0]        w_best_x4;
    logic [10:0]        w_second_x3;
    logic               w_accept;
    logic               w_match_nxt;

    assign w_start_acc  = (r_state == IDLE) && bus.i_start;
    assign w_res_acc    = bus.i_ham_valid && ((r_state == FETCH) || (r_state == DRAIN));
    assign w_num_lat    = (bus.i_dst_num > NUM_MAX) ? NUM_MAX : bus.i_dst_num;
    assign w_issue_inc  = r_issue_cnt + 1'b1;
    assign w_res_inc    = r_res_cnt + 1'b1;
    assign w_last_issue = (w_issue_inc == r_num);
    // DONE is entered on the edge that registers the last result.
    assign w_last_res   = w_res_acc && (w_res_inc == r_num);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (bus.i_start) w_state_nxt = (w_num_lat == '0) ? DONE : FETCH;
            FETCH:   if (w_last_issue) w_state_nxt = DRAIN;
            DRAIN:   if (w_last_res) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_issue_nxt    = r_issue_cnt;
        w_res_nxt      = r_res_cnt;
        w_dst_ren_nxt  = 1'b0;
        w_best_idx_nxt = r_best_idx;
        w_best_nxt     = r_best;
        w_second_nxt   = r_second;

        if (w_start_acc) begin
            w_issue_nxt    = '0;
            w_res_nxt      = '0;
            w_dst_ren_nxt  = (w_num_lat != '0);
            w_best_idx_nxt = '0;
            w_best_nxt     = '1;
            w_second_nxt   = '1;
        end else begin
            if (r_state == FETCH) begin
                w_issue_nxt   = w_issue_inc;
                w_dst_ren_nxt = !w_last_issue;
            end
            if (w_res_acc) begin
                w_res_nxt = w_res_inc;
                if (bus.i_ham_dist < r_best) begin
                    w_second_nxt   = r_best;
                    w_best_nxt     = bus.i_ham_dist;
                    w_best_idx_nxt = r_res_cnt[IDX_W-1:0];
                end else if (bus.i_ham_dist < r_second) begin
                    w_second_nxt = bus.i_ham_dist;
                end
            end
        end

        // Ratio test evaluated on the values being registered this edge.
        w_best_x4   = {w_best_nxt, 2'b00};
        w_second_x3 = {2'b00, w_second_nxt} + {1'b0, w_second_nxt, 1'b0};
        w_accept    = (w_best_nxt <= MAX_D) && (w_best_x4 < w_second_x3);

        if (w_state_nxt == DONE) w_match_nxt = w_accept;
        else if (w_start_acc)    w_match_nxt = 1'b0;
        else                     w_match_nxt = r_match_valid;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_src         <= '0;
            r_num         <= '0;
            r_issue_cnt   <= '0;
            r_res_cnt     <= '0;
            r_dst_ren     <= 1'b0;
            r_ham_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_match_valid <= 1'b0;
            r_best_idx    <= '0;
            r_best        <= '1;
            r_second      <= '1;
        end else begin
            if (w_start_acc) begin
                r_src <= bus.i_src_desc;
                r_num <= w_num_lat;
            end
            r_issue_cnt   <= w_issue_nxt;
            r_res_cnt     <= w_res_nxt;
            r_dst_ren     <= w_dst_ren_nxt;
            r_ham_valid   <= r_dst_ren;
            r_busy        <= (w_state_nxt == FETCH) || (w_state_nxt == DRAIN);
            r_done        <= (w_state_nxt == DONE);
            r_match_valid <= w_match_nxt;
            r_best_idx    <= w_best_idx_nxt;
            r_best        <= w_best_nxt;
            r_second      <= w_second_nxt;
        end
    end

    assign bus.o_dst_ren     = r_dst_ren;
    assign bus.o_dst_addr    = r_issue_cnt[IDX_W-1:0];
    assign bus.o_ham_valid   = r_ham_valid;
    assign bus.o_ham_src     = r_src;
    assign bus.o_ham_dst     = bus.i_dst_desc;
    assign bus.o_busy        = r_busy;
    assign bus.o_done        = r_done;
    assign bus.o_best_idx    = r_best_idx;
    assign bus.o_best_dist   = r_best;
    assign bus.o_second_dist = r_second;
    assign bus.o_match_valid = r_match_valid;
endmodule

// File: tb/tb_hamming_match_ctrl.sv
// Directed bench for hamming_match_ctrl with a behavioural descriptor buffer
// and 2-stage Hamming unit; distances are set by constructing descriptors.
module tb_hamming_match_ctrl;
    localparam int IDX_W = 6;

    typedef struct {
        int n;
        int d[4];
        int tail;
        int last;
        bit pulse;
        int e_idx;
        int e_best;
        int e_second;
        int e_mv;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hamming_match_ctrl_if #(.IDX_W(IDX_W)) bus ();

    hamming_match_ctrl #(.N_DST(64), .IDX_W(IDX_W), .MAX_DIST(64)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    logic [255:0] mem [64];
    logic [255:0] dst_q = '0;
    logic         s1v = 1'b0, s2v = 1'b0;
    logic [8:0]   s1d = '0,   s2d = '0;

    always @(posedge clk) begin
        if (bus.o_dst_ren) dst_q <= mem[bus.o_dst_addr];
        s1v <= bus.o_ham_valid;
        s1d <= 9'($countones(bus.o_ham_src ^ bus.o_ham_dst));
        s2v <= s1v;
        s2d <= s1d;
    end
    assign bus.i_dst_desc  = dst_q;
    assign bus.i_ham_valid = s2v;
    assign bus.i_ham_dist  = s2d;

    int total = 0;
    int bad   = 0;
    vec_t vt[11];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [255:0] desc_for(input int d);
        logic [255:0] one;
        one = 256'd1;
        if (d >= 256) return '1;
        return (one << d) - one;
    endfunction

    function automatic vec_t mk(input int n, input int d0, input int d1, input int d2, input int d3,
                                input int tail, input int last, input bit pulse,
                                input int ei, input int eb, input int es, input int em);
        vec_t v;
        v.n = n; v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        v.tail = tail; v.last = last; v.pulse = pulse;
        v.e_idx = ei; v.e_best = eb; v.e_second = es; v.e_mv = em;
        return v;
    endfunction

    task automatic run_search(input vec_t v, input string tag);
        logic [255:0] x;
        int dd, done_cyc, ren_cnt, addr_err, hv_cnt, busy1, busy_done;
        for (int w = 0; w < 8; w++) x[w*32 +: 32] = $urandom;
        for (int i = 0; i < 64; i++) begin
            dd = (i < 4) ? v.d[i] : ((i == v.n - 1) ? v.last : v.tail);
            mem[i] = x ^ desc_for(dd);
        end
        done_cyc = -1; ren_cnt = 0; addr_err = 0; hv_cnt = 0; busy1 = 0; busy_done = 1;
        @(posedge clk); #1;
        bus.i_start = 1'b1; bus.i_dst_num = 7'(v.n); bus.i_src_desc = x;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            bus.i_start = v.pulse && (c == 2);
            if (v.pulse && c == 2) bus.i_dst_num = 7'd7;
            bus.i_src_desc = ~x;
            @(negedge clk);
            if (bus.o_dst_ren) begin
                if (int'(bus.o_dst_addr) != ren_cnt || c != ren_cnt + 1) addr_err++;
                ren_cnt++;
            end
            if (bus.o_ham_valid) hv_cnt++;
            if (c == 1) busy1 = bus.o_busy;
            if (bus.o_done) begin
                done_cyc  = c;
                busy_done = bus.o_busy;
                break;
            end
        end
        check({tag, " done_cycle"}, done_cyc, (v.n == 0) ? 1 : v.n + 4);
        check({tag, " ren_count"}, ren_cnt, v.n);
        check({tag, " addr_errors"}, addr_err, 0);
        check({tag, " ham_valid_count"}, hv_cnt, v.n);
        check({tag, " busy_cycle1"}, busy1, (v.n > 0) ? 1 : 0);
        check({tag, " busy_at_done"}, busy_done, 0);
        check({tag, " best_idx"}, int'(bus.o_best_idx), v.e_idx);
        check({tag, " best_dist"}, int'(bus.o_best_dist), v.e_best);
        check({tag, " second_dist"}, int'(bus.o_second_dist), v.e_second);
        check({tag, " match_valid"}, int'(bus.o_match_valid), v.e_mv);
        @(negedge clk);
        check({tag, " done_pulse_end"}, int'(bus.o_done), 0);
        check({tag, " best_held"}, int'(bus.o_best_dist), v.e_best);
        check({tag, " match_held"}, int'(bus.o_match_valid), v.e_mv);
        repeat (4) @(posedge clk);
    endtask

    task automatic reset_midsearch();
        logic [255:0] x;
        int done_seen, busy_seen;
        x = {8{32'hA5C3_0F1E}};
        for (int i = 0; i < 64; i++) mem[i] = x ^ desc_for(20);
        @(posedge clk); #1;
        bus.i_start = 1'b1; bus.i_dst_num = 7'd8; bus.i_src_desc = x;
        @(posedge clk); #1; bus.i_start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; rst_n = 1'b0;
        #1;
        check("rst_mid dst_ren", int'(bus.o_dst_ren), 0);
        check("rst_mid dst_addr", int'(bus.o_dst_addr), 0);
        check("rst_mid ham_valid", int'(bus.o_ham_valid), 0);
        check("rst_mid busy", int'(bus.o_busy), 0);
        check("rst_mid best_dist", int'(bus.o_best_dist), 511);
        check("rst_mid second_dist", int'(bus.o_second_dist), 511);
        @(posedge clk); #1; rst_n = 1'b1;
        done_seen = 0; busy_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.o_done) done_seen = 1;
            if (bus.o_busy) busy_seen = 1;
        end
        check("rst_mid no_done", done_seen, 0);
        check("rst_mid no_busy", busy_seen, 0);
        check("rst_mid late_result_ignored", int'(bus.o_best_dist), 511);
        check("rst_mid best_idx", int'(bus.o_best_idx), 0);
        check("rst_mid match_valid", int'(bus.o_match_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        bus.i_start = 1'b0; bus.i_dst_num = '0; bus.i_src_desc = '0;
        for (int i = 0; i < 64; i++) mem[i] = '0;

        vt[0]  = mk(4,  40, 10, 30, 20,   0, 0, 1'b0,  1, 10,  20, 1);
        vt[1]  = mk(3,  12, 12, 50,  0,   0, 0, 1'b0,  0, 12,  12, 0);
        vt[2]  = mk(1,  70,  0,  0,  0,   0, 0, 1'b0,  0, 70, 511, 0);
        vt[3]  = mk(1,   5,  0,  0,  0,   0, 0, 1'b0,  0,  5, 511, 1);
        vt[4]  = mk(0,   0,  0,  0,  0,   0, 0, 1'b0,  0, 511, 511, 0);
        vt[5]  = mk(64, 256, 256, 256, 256, 256, 0, 1'b0, 63, 0, 256, 1);
        vt[6]  = mk(4,  40, 10, 30, 20,   0, 0, 1'b1,  1, 10,  20, 1);
        vt[7]  = mk(2,  64, 100, 0,  0,   0, 0, 1'b0,  0, 64, 100, 1);
        vt[8]  = mk(2,  30, 40,  0,  0,   0, 0, 1'b0,  0, 30,  40, 0);
        vt[9]  = mk(2,  65, 200, 0,  0,   0, 0, 1'b0,  0, 65, 200, 0);
        vt[10] = mk(3,   9,  3,  3,  0,   0, 0, 1'b0,  1,  3,   3, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset dst_ren", int'(bus.o_dst_ren), 0);
        check("reset ham_valid", int'(bus.o_ham_valid), 0);
        check("reset busy", int'(bus.o_busy), 0);
        check("reset done", int'(bus.o_done), 0);
        check("reset match_valid", int'(bus.o_match_valid), 0);
        check("reset best_idx", int'(bus.o_best_idx), 0);
        check("reset best_dist", int'(bus.o_best_dist), 511);
        check("reset second_dist", int'(bus.o_second_dist), 511);
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int k = 0; k < 11; k++) run_search(vt[k], $sformatf("vec%0d", k));

        reset_midsearch();
        run_search(vt[0], "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
